// File: rtl/sram_fifo_ctrl_if.sv
// rtl/sram_fifo_ctrl_if.sv - producer/consumer handshakes plus sram8t17x64 port bundle for sram_fifo_ctrl
interface sram_fifo_ctrl_if #(
    parameter int WIDTH = 64,
    parameter int AW    = 5,
    parameter int CW    = 5
);
    logic             enq_valid;
    logic             enq_ready;
    logic [WIDTH-1:0] enq_data;
    logic             deq_valid;
    logic             deq_ready;
    logic [WIDTH-1:0] deq_data;
    logic [CW-1:0]    count;
    logic [AW-1:0]    sram_a1;
    logic             sram_csb1;
    logic             sram_oeb1;
    logic [WIDTH-1:0] sram_o1;
    logic [AW-1:0]    sram_a2;
    logic             sram_csb2;
    logic             sram_web2;
    logic [WIDTH-1:0] sram_i2;

    // Controller side.
    modport master (
        input  enq_valid, enq_data, deq_ready, sram_o1,
        output enq_ready, deq_valid, deq_data, count,
        output sram_a1, sram_csb1, sram_oeb1, sram_a2, sram_csb2, sram_web2, sram_i2
    );

    // Producer/consumer and SRAM macro side.
    modport slave (
        output enq_valid, enq_data, deq_ready, sram_o1,
        input  enq_ready, deq_valid, deq_data, count,
        input  sram_a1, sram_csb1, sram_oeb1, sram_a2, sram_csb2, sram_web2, sram_i2
    );
endinterface

// File: rtl/sram_fifo_ctrl.sv
// rtl/sram_fifo_ctrl.sv - sram8t17x64 sequenced as a ready/valid FIFO with a 2-entry prefetch output stage
// Optional SRAM_FIFO_BYPASS_EN: enq goes straight to the output stage when nothing is queued ahead.
module sram_fifo_ctrl #(
    parameter int DEPTH = 17,
    parameter int WIDTH = 64,
    parameter int AW    = 5,
    parameter int CW    = 5
) (
    input  logic              clock,
    input  logic              reset,
    sram_fifo_ctrl_if.master  bus
);
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);

    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [CW-1:0]    mem_cnt;
    logic             rd_pend;
    logic [1:0]       out_occ;
    logic [WIDTH-1:0] out0, out1;

    logic [AW-1:0]    wr_ptr_n, rd_ptr_n;
    logic [CW-1:0]    mem_cnt_n;
    logic [1:0]       out_occ_n;
    logic [WIDTH-1:0] out0_n, out1_n;

    logic             enq_fire, deq_fire, wr_en, rd_issue, bypass, push;
    logic [1:0]       occ_post;
    logic [WIDTH-1:0] push_data;

    function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + AW'(1);
    endfunction

    assign bus.enq_ready = (mem_cnt != DEPTH_C);
    assign bus.deq_valid = (out_occ != 2'd0);
    assign bus.deq_data  = out0;
    assign bus.count     = mem_cnt + CW'(rd_pend) + CW'(out_occ);

    assign enq_fire = bus.enq_valid && bus.enq_ready;
    assign deq_fire = bus.deq_valid && bus.deq_ready;
    assign occ_post = out_occ - {1'b0, deq_fire};

`ifdef SRAM_FIFO_BYPASS_EN
    assign bypass = enq_fire && (mem_cnt == '0) && !rd_pend && (occ_post != 2'd2);
`else
    assign bypass = 1'b0;
`endif

    assign wr_en = enq_fire && !bypass;
    // Prefetch only while the output stage still has room for the word in flight.
    assign rd_issue = (mem_cnt != '0) && (({1'b0, out_occ} + {2'b00, rd_pend}) < 3'd2);

    assign bus.sram_a1   = rd_ptr;
    assign bus.sram_csb1 = !rd_issue;
    assign bus.sram_oeb1 = 1'b0;
    assign bus.sram_a2   = wr_ptr;
    assign bus.sram_csb2 = !wr_en;
    assign bus.sram_web2 = !wr_en;
    assign bus.sram_i2   = bus.enq_data;

    // rd_pend and bypass are mutually exclusive, so one push source per cycle.
    assign push      = rd_pend || bypass;
    assign push_data = rd_pend ? bus.sram_o1 : bus.enq_data;

    always_comb begin
        wr_ptr_n  = wr_en ? next_ptr(wr_ptr) : wr_ptr;
        rd_ptr_n  = rd_issue ? next_ptr(rd_ptr) : rd_ptr;
        mem_cnt_n = mem_cnt;
        case ({wr_en, rd_issue})
            2'b10:   mem_cnt_n = mem_cnt + CW'(1);
            2'b01:   mem_cnt_n = mem_cnt - CW'(1);
            default: mem_cnt_n = mem_cnt;
        endcase
    end

    always_comb begin
        out0_n    = out0;
        out1_n    = out1;
        out_occ_n = occ_post + {1'b0, push};
        if (deq_fire) begin
            out0_n = out1;
        end
        // The new word lands in the first free slot after this cycle's dequeue.
        if (push) begin
            if (occ_post == 2'd0) begin
                out0_n = push_data;
            end else begin
                out1_n = push_data;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            mem_cnt <= '0;
            rd_pend <= 1'b0;
            out_occ <= 2'd0;
            out0    <= '0;
            out1    <= '0;
        end else begin
            wr_ptr  <= wr_ptr_n;
            rd_ptr  <= rd_ptr_n;
            mem_cnt <= mem_cnt_n;
            rd_pend <= rd_issue;
            out_occ <= out_occ_n;
            out0    <= out0_n;
            out1    <= out1_n;
        end
    end
endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// tb/tb_sram_fifo_ctrl.sv - self-checking bench for sram_fifo_ctrl with SRAM model and queue reference
module tb_sram_fifo_ctrl;
`ifdef SRAM_FIFO_BYPASS_EN
    localparam int EXP_LAT = 1;
`else
    localparam int EXP_LAT = 3;
`endif

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    sram_fifo_ctrl_if #(.WIDTH(64), .AW(5), .CW(5)) bus ();

    sram_fifo_ctrl #(.DEPTH(17), .WIDTH(64), .AW(5), .CW(5)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    logic [63:0] mem [0:31];
    always @(posedge clock) begin
        if (!bus.sram_csb2 && !bus.sram_web2) mem[bus.sram_a2] <= bus.sram_i2;
        if (!bus.sram_csb1) bus.sram_o1 <= mem[bus.sram_a1];
    end

    int          checks = 0;
    int          errors = 0;
    logic [63:0] q [$];
    bit          written [0:31];
    int          last_a1 = -1, last_a2 = -1, wraps1 = 0, wraps2 = 0;
    int          n_deq = 0;
    logic        s_enq_f, s_deq_f, s_enq_ready;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic ev, input logic [63:0] ed, input logic dr);
        logic [63:0] exp;
        @(negedge clock);
        bus.enq_valid = ev;
        bus.enq_data  = ed;
        bus.deq_ready = dr;
        #1;
        check("count_model", 64'(bus.count), 64'(q.size()));
        check("enq_ready_only_when_mem_full", 64'((bus.enq_ready === 1'b1) || (q.size() >= 17)), 64'd1);
        if (bus.sram_csb1 === 1'b0) begin
            check("read_of_written_addr", 64'(written[bus.sram_a1]), 64'd1);
            written[bus.sram_a1] = 1'b0;
            if (last_a1 == 16 && bus.sram_a1 == 5'd0) wraps1++;
            last_a1 = int'(bus.sram_a1);
        end
        if (bus.sram_csb2 === 1'b0 && bus.sram_web2 === 1'b0) begin
            written[bus.sram_a2] = 1'b1;
            if (last_a2 == 16 && bus.sram_a2 == 5'd0) wraps2++;
            last_a2 = int'(bus.sram_a2);
        end
        s_enq_ready = bus.enq_ready;
        s_enq_f = ev && (bus.enq_ready === 1'b1);
        s_deq_f = (bus.deq_valid === 1'b1) && dr;
        if (s_deq_f) begin
            n_deq++;
            if (q.size() == 0) begin
                check("deq_from_empty_model", 64'd1, 64'd0);
            end else begin
                exp = q.pop_front();
                check("deq_data_order", bus.deq_data, exp);
            end
        end
        if (s_enq_f) q.push_back(ed);
    endtask

    task automatic do_reset();
        @(negedge clock);
        #2;
        reset = 1'b1;
        bus.enq_valid = 1'b0;
        bus.deq_ready = 1'b0;
        #1;
        check("rst_deq_valid", 64'(bus.deq_valid), 64'd0);
        check("rst_count", 64'(bus.count), 64'd0);
        check("rst_enq_ready", 64'(bus.enq_ready), 64'd1);
        check("rst_csb1", 64'(bus.sram_csb1), 64'd1);
        check("rst_csb2", 64'(bus.sram_csb2), 64'd1);
        check("rst_web2", 64'(bus.sram_web2), 64'd1);
        check("rst_oeb1", 64'(bus.sram_oeb1), 64'd0);
        q.delete();
        for (int i = 0; i < 32; i++) written[i] = 1'b0;
        last_a1 = -1;
        last_a2 = -1;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        int lat, got, acc, sent, n0;
        bus.enq_valid = 1'b0;
        bus.enq_data  = '0;
        bus.deq_ready = 1'b0;

        // T1: reset
        do_reset();
        cyc(0, 64'd0, 0);

        // T2: single word latency
        cyc(1, 64'hDEAD_BEEF_0000_0001, 1);
        got = 0;
        lat = 0;
        for (int i = 1; i <= 8; i++) begin
            if (got == 0) begin
                cyc(0, 64'd0, 1);
                if (s_deq_f) begin
                    got = 1;
                    lat = i;
                end
            end
        end
        check("t2_got", 64'(got), 64'd1);
        check("t2_latency", 64'(lat), 64'(EXP_LAT));
        cyc(0, 64'd0, 0);
        check("t2_count", 64'(bus.count), 64'd0);

        // T3: fill with 25 offers, then drain in order
        acc = 0;
        for (int i = 0; i < 25; i++) begin
            cyc(1, 64'(acc), 0);
            if (s_enq_f) acc++;
        end
        cyc(0, 64'd0, 0);
        check("t3_accepted", 64'(acc), 64'd19);
        check("t3_count", 64'(bus.count), 64'd19);
        check("t3_enq_ready", 64'(bus.enq_ready), 64'd0);
        n0 = n_deq;
        for (int i = 0; i < 60; i++) if (q.size() > 0) cyc(0, 64'd0, 1);
        check("t3_drained", 64'(n_deq - n0), 64'd19);

        // T5: full plus dequeue
        for (int i = 0; i < 60; i++) if (q.size() < 19) cyc(1, 64'h200 + 64'(i), 0);
        cyc(0, 64'd0, 0);
        check("t5_full_count", 64'(bus.count), 64'd19);
        cyc(1, 64'h300, 1);
        check("t5_enq_blocked", 64'(s_enq_f), 64'd0);
        check("t5_deq_fired", 64'(s_deq_f), 64'd1);
        got = 0;
        for (int i = 0; i < 4; i++) begin
            if (got == 0) begin
                cyc(1, 64'h301, 0);
                if (s_enq_f) got = 1;
            end
        end
        check("t5_refill_enq", 64'(got), 64'd1);
        cyc(0, 64'd0, 0);
        cyc(0, 64'd0, 0);
        check("t5_count_back", 64'(bus.count), 64'd19);
        check("t5_enq_ready_low", 64'(bus.enq_ready), 64'd0);
        for (int i = 0; i < 60; i++) if (q.size() > 0) cyc(0, 64'd0, 1);
        check("t5_empty", 64'(q.size()), 64'd0);

        // T4: random streaming with pointer wrap
        wraps1 = 0;
        wraps2 = 0;
        sent = 0;
        n0 = n_deq;
        for (int c = 0; c < 3000; c++) begin
            if ((n_deq - n0) < 60) begin
                cyc((sent < 60) && ($urandom_range(0, 1) == 1), 64'h1000 + 64'(sent),
                    $urandom_range(0, 1) == 1);
                if (s_enq_f) sent++;
            end
        end
        check("t4_all_received", 64'(n_deq - n0), 64'd60);
`ifndef SRAM_FIFO_BYPASS_EN
        check("t4_a1_wraps", 64'(wraps1 >= 3), 64'd1);
        check("t4_a2_wraps", 64'(wraps2 >= 3), 64'd1);
`endif

        // T6: reset mid-stream
        for (int i = 0; i < 7; i++) cyc(1, 64'h700 + 64'(i), 0);
        cyc(0, 64'd0, 0);
        cyc(0, 64'd0, 0);
        cyc(0, 64'd0, 0);
        check("t6_count_7", 64'(bus.count), 64'd7);
        do_reset();
        cyc(1, 64'h5, 1);
        n0 = n_deq;
        for (int i = 0; i < 10; i++) cyc(0, 64'd0, 1);
        check("t6_one_deq", 64'(n_deq - n0), 64'd1);
        check("t6_count_0", 64'(bus.count), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
